rst_seq_ctrl: RTL and testbench

Reset sequencer for the 40G switch core: consumes the synchronized active-low reset from the per-domain reset synchronizer and produces staged, glitch-free resets for the PCS, MAC and switch-core logic. Release is gated on a stable PLL lock and ordered PCS → MAC → core with programmable gaps. It also services single-cycle soft-reset requests that re-reset MAC and core without disturbing the PCS.

---
 rtl/rst_seq_ctrl.sv | 205 ++++++++++++++++++++
 tb/tb_rst_seq_ctrl.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/rst_seq_ctrl.sv
// -----------------------------------------------------------------------------
// rst_seq_ctrl
//
// Reset sequencer for the 40G switch core. Takes the synchronized active-low
// reset and releases the PCS, MAC and switch-core resets in that order. PCS
// release waits for a stable PLL lock. Each later stage waits a programmable
// gap before it is released. Once everything is up, a one-cycle soft-reset
// request re-resets MAC and core and leaves the PCS alone.
//
// Optional feature macro: RST_SEQ_LOCK_LOSS_EN
//   defined   : losing PLL lock after PCS release drops every output and
//               restarts the whole sequence from WAIT_LOCK.
//   undefined : iPllLocked is only looked at while waiting for lock.
//
// Parameters
//   LOCK_WAIT_CYCLES  consecutive locked samples before PCS release (>=1)
//   STAGE_GAP_CYCLES  edges between successive stage releases      (>=1)
//   SOFT_RST_CYCLES   edges MAC/core are held in soft reset        (>=1)
//   CNT_W             shared counter width (all counts must fit)
//
// Ports
//   Clock        in   core clock, rising edge
//   qnReset      in   asynchronous active-low reset
//   iPllLocked   in   PLL lock status (Clock domain)
//   iSoftRstReq  in   one-cycle soft-reset request
//   oPcsRstN     out  PCS reset, active-low
//   oMacRstN     out  MAC reset, active-low
//   oCoreRstN    out  switch-core reset, active-low
//   oSeqDone     out  all stages released
//   oSoftRstAck  out  one-cycle pulse when a soft reset completes
// -----------------------------------------------------------------------------
module rst_seq_ctrl #(
  parameter int LOCK_WAIT_CYCLES = 64,
  parameter int STAGE_GAP_CYCLES = 16,
  parameter int SOFT_RST_CYCLES  = 32,
  parameter int CNT_W            = 16
) (
  input  logic Clock,
  input  logic qnReset,
  input  logic iPllLocked,
  input  logic iSoftRstReq,
  output logic oPcsRstN,
  output logic oMacRstN,
  output logic oCoreRstN,
  output logic oSeqDone,
  output logic oSoftRstAck
);

  typedef enum logic [2:0] {
    WAIT_LOCK = 3'd0,
    GAP_MAC   = 3'd1,
    GAP_CORE  = 3'd2,
    DONE      = 3'd3,
    SOFT_HOLD = 3'd4,
    SOFT_GAP  = 3'd5
  } state_t;

  // Terminal counts: the counter starts at 0 on entry to a state, so the
  // N-th edge in that state sees the value N-1.
  localparam logic [CNT_W-1:0] LOCK_LAST = CNT_W'(LOCK_WAIT_CYCLES - 1);
  localparam logic [CNT_W-1:0] GAP_LAST  = CNT_W'(STAGE_GAP_CYCLES - 1);
  localparam logic [CNT_W-1:0] SOFT_LAST = CNT_W'(SOFT_RST_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_ZERO  = '0;

  state_t           state_reg, state_next;
  logic [CNT_W-1:0] cnt_reg, cnt_next;
  logic             pcs_reg, pcs_next;
  logic             mac_reg, mac_next;
  logic             core_reg, core_next;
  logic             done_reg, done_next;
  logic             ack_reg, ack_next;

  // State, counter and every output are registered together so the reset
  // lines can never glitch.
  always_ff @(posedge Clock or negedge qnReset) begin
    if (!qnReset) begin
      state_reg <= WAIT_LOCK;
      cnt_reg   <= CNT_ZERO;
      pcs_reg   <= 1'b0;
      mac_reg   <= 1'b0;
      core_reg  <= 1'b0;
      done_reg  <= 1'b0;
      ack_reg   <= 1'b0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
      pcs_reg   <= pcs_next;
      mac_reg   <= mac_next;
      core_reg  <= core_next;
      done_reg  <= done_next;
      ack_reg   <= ack_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    pcs_next   = pcs_reg;
    mac_next   = mac_reg;
    core_next  = core_reg;
    done_next  = done_reg;
    ack_next   = 1'b0;  // ack is a single-cycle pulse

    case (state_reg)
      WAIT_LOCK: begin
        // Any unlocked sample restarts the stability count.
        if (!iPllLocked) begin
          cnt_next = CNT_ZERO;
        end else if (cnt_reg == LOCK_LAST) begin
          pcs_next   = 1'b1;
          cnt_next   = CNT_ZERO;
          state_next = GAP_MAC;
        end else begin
          cnt_next = cnt_reg + CNT_ONE;
        end
      end

      GAP_MAC: begin
        if (cnt_reg == GAP_LAST) begin
          mac_next   = 1'b1;
          cnt_next   = CNT_ZERO;
          state_next = GAP_CORE;
        end else begin
          cnt_next = cnt_reg + CNT_ONE;
        end
      end

      GAP_CORE: begin
        if (cnt_reg == GAP_LAST) begin
          core_next  = 1'b1;
          done_next  = 1'b1;
          cnt_next   = CNT_ZERO;
          state_next = DONE;
        end else begin
          cnt_next = cnt_reg + CNT_ONE;
        end
      end

      DONE: begin
        // Soft reset only touches MAC and core; PCS stays released.
        if (iSoftRstReq) begin
          mac_next   = 1'b0;
          core_next  = 1'b0;
          done_next  = 1'b0;
          cnt_next   = CNT_ZERO;
          state_next = SOFT_HOLD;
        end
      end

      SOFT_HOLD: begin
        if (cnt_reg == SOFT_LAST) begin
          mac_next   = 1'b1;
          cnt_next   = CNT_ZERO;
          state_next = SOFT_GAP;
        end else begin
          cnt_next = cnt_reg + CNT_ONE;
        end
      end

      SOFT_GAP: begin
        if (cnt_reg == GAP_LAST) begin
          core_next  = 1'b1;
          done_next  = 1'b1;
          ack_next   = 1'b1;
          cnt_next   = CNT_ZERO;
          state_next = DONE;
        end else begin
          cnt_next = cnt_reg + CNT_ONE;
        end
      end

      default: begin
        // Unreachable encodings fall back to the fully-reset state.
        state_next = WAIT_LOCK;
        cnt_next   = CNT_ZERO;
        pcs_next   = 1'b0;
        mac_next   = 1'b0;
        core_next  = 1'b0;
        done_next  = 1'b0;
      end
    endcase

`ifdef RST_SEQ_LOCK_LOSS_EN
    // Lock loss after PCS release overrides everything, including a soft
    // request on the same edge: drop all resets and resequence from scratch.
    if (state_reg != WAIT_LOCK && !iPllLocked) begin
      state_next = WAIT_LOCK;
      cnt_next   = CNT_ZERO;
      pcs_next   = 1'b0;
      mac_next   = 1'b0;
      core_next  = 1'b0;
      done_next  = 1'b0;
      ack_next   = 1'b0;
    end
`endif
  end

  assign oPcsRstN    = pcs_reg;
  assign oMacRstN    = mac_reg;
  assign oCoreRstN   = core_reg;
  assign oSeqDone    = done_reg;
  assign oSoftRstAck = ack_reg;

endmodule

// File: tb/tb_rst_seq_ctrl.sv
// -----------------------------------------------------------------------------
// tb_rst_seq_ctrl
//
// Scoreboard bench for rst_seq_ctrl with default parameters (64/16/32).
// Stimulus pushes the expected output changes (edge number + output vector
// {pcs, mac, core, done, ack}) into a queue; monitors pop an entry whenever
// the outputs change at a clock edge, or whenever qnReset falls.
// Edge numbering: edge 1 is the first rising edge after qnReset release.
// -----------------------------------------------------------------------------
module tb_rst_seq_ctrl;

  logic Clock = 1'b0;
  logic qnReset = 1'b1;
  logic iPllLocked = 1'b0;
  logic iSoftRstReq = 1'b0;
  logic oPcsRstN, oMacRstN, oCoreRstN, oSeqDone, oSoftRstAck;

  rst_seq_ctrl dut (
    .Clock       (Clock),
    .qnReset     (qnReset),
    .iPllLocked  (iPllLocked),
    .iSoftRstReq (iSoftRstReq),
    .oPcsRstN    (oPcsRstN),
    .oMacRstN    (oMacRstN),
    .oCoreRstN   (oCoreRstN),
    .oSeqDone    (oSeqDone),
    .oSoftRstAck (oSoftRstAck)
  );

  always #5 Clock = ~Clock;

  typedef struct {
    string      name;
    int         edge_no;  // -1: asynchronous event on qnReset fall
    logic [4:0] outs;
  } exp_t;

  exp_t       exp_q[$];
  int         checks = 0;
  int         errors = 0;
  int         edge_cnt = 0;
  logic [4:0] prev_outs = 5'b0;
  logic [4:0] outs;

  assign outs = {oPcsRstN, oMacRstN, oCoreRstN, oSeqDone, oSoftRstAck};

  always @(posedge Clock) edge_cnt <= qnReset ? edge_cnt + 1 : 0;

  task automatic expect_ev(input string name, input int e, input logic [4:0] v);
    exp_t x;
    x.name = name;
    x.edge_no = e;
    x.outs = v;
    exp_q.push_back(x);
  endtask

  task automatic check_pop();
    exp_t x;
    checks++;
    if (exp_q.size() == 0) begin
      errors++;
      $display("FAIL unexpected: edge %0d outs %b, no change was expected", edge_cnt, outs);
    end else begin
      x = exp_q.pop_front();
      if ((x.edge_no != -1 && x.edge_no != edge_cnt) || outs !== x.outs) begin
        errors++;
        $display("FAIL %s: edge %0d outs %b, expected edge %0d outs %b",
                 x.name, edge_cnt, outs, x.edge_no, x.outs);
      end else begin
        $display("ok   %s: edge %0d outs %b", x.name, edge_cnt, outs);
      end
    end
    prev_outs = outs;
  endtask

  // Monitors
  always @(negedge qnReset) begin
    #1;
    check_pop();
  end

  always @(posedge Clock) begin
    #1;
    if (outs !== prev_outs) check_pop();
  end

  // Stimulus helpers (called at a falling clock edge)
  task automatic wait_edge(input int n);
    int guard;
    guard = 0;
    while (edge_cnt < n && guard < 2000) begin
      @(negedge Clock);
      guard++;
    end
    if (edge_cnt < n) begin
      checks++;
      errors++;
      $display("FAIL timeout: edge %0d, expected to reach edge %0d", edge_cnt, n);
    end
  endtask

  task automatic assert_reset(input string name);
    expect_ev(name, -1, 5'b00000);
    qnReset = 1'b0;
  endtask

  task automatic do_release();
    repeat (2) @(posedge Clock);
    #4;
    qnReset = 1'b1;
  endtask

  // Request driven after edge N, sampled at edge N+1.
  task automatic pulse_req();
    iSoftRstReq = 1'b1;
    @(negedge Clock);
    iSoftRstReq = 1'b0;
  endtask

  initial begin
    // Power-on reset and baseline sequence
    #2;
    assert_reset("por");
    iPllLocked = 1'b1;
    do_release();
    expect_ev("base pcs", 64, 5'b10000);
    expect_ev("base mac", 80, 5'b11000);
    expect_ev("base core", 96, 5'b11110);

    // Soft reset in DONE at N=100, second request during SOFT_HOLD ignored
    wait_edge(100);
    expect_ev("soft fall", 101, 5'b10000);
    expect_ev("soft mac", 133, 5'b11000);
    expect_ev("soft core+ack", 149, 5'b11111);
    expect_ev("soft ack off", 150, 5'b11110);
    pulse_req();
    wait_edge(110);
    pulse_req();
    wait_edge(160);

    // Lock glitch: locked edges 1..40, unlocked edge 41, locked from 42
    #2;
    assert_reset("rst glitch");
    do_release();
    expect_ev("glitch pcs", 105, 5'b10000);
    expect_ev("glitch mac", 121, 5'b11000);
    expect_ev("glitch core", 137, 5'b11110);
    wait_edge(20);
    pulse_req();           // WAIT_LOCK: ignored
    wait_edge(40);
    iPllLocked = 1'b0;
    @(negedge Clock);
    iPllLocked = 1'b1;
    wait_edge(110);
    pulse_req();           // GAP_MAC: ignored
    wait_edge(140);

    // Soft reset at N=145, lock dropped for edge 161 (inside SOFT_HOLD)
    wait_edge(145);
    expect_ev("s4 soft fall", 146, 5'b10000);
    pulse_req();
    wait_edge(160);
`ifdef RST_SEQ_LOCK_LOSS_EN
    expect_ev("s4 lockloss", 161, 5'b00000);
    expect_ev("s4 re pcs", 225, 5'b10000);
    expect_ev("s4 re mac", 241, 5'b11000);
    expect_ev("s4 re core", 257, 5'b11110);
`else
    expect_ev("s4 mac", 178, 5'b11000);
    expect_ev("s4 core+ack", 194, 5'b11111);
    expect_ev("s4 ack off", 195, 5'b11110);
`endif
    iPllLocked = 1'b0;
    @(negedge Clock);
    iPllLocked = 1'b1;
    wait_edge(262);

    // qnReset pulsed mid-GAP_CORE, then the baseline timing repeats
    #2;
    assert_reset("rst s5");
    do_release();
    expect_ev("s5 pcs", 64, 5'b10000);
    expect_ev("s5 mac", 80, 5'b11000);
    wait_edge(85);
    #2;
    assert_reset("mid core reset");
    do_release();
    expect_ev("after pcs", 64, 5'b10000);
    expect_ev("after mac", 80, 5'b11000);
    expect_ev("after core", 96, 5'b11110);
    wait_edge(105);

    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d expected events outstanding, required 0 (next %s)",
               exp_q.size(), exp_q[0].name);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
